z_core_alu_seq: RTL and testbench
=================================

Z_CORE_ALU_SEQ -- requirements
Module: z_core_alu_seq

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rstn  input  1  reset; asynchronous, active-low.
REQ-004 flush  input  1  synchronous abort of the in-flight operation.
REQ-005 in_valid  input  1  operation offered.
REQ-006 in_ready  output  1  sequencer can accept an operation.
REQ-007 in_op  input  7  instruction opcode field.
REQ-008 in_funct3  input  3  instruction funct3 field.
REQ-009 in_funct7  input  7  instruction funct7 field.
REQ-010 in_a  input  XLEN  operand A (rs1 or PC).
REQ-011 in_b  input  XLEN  operand B (rs2 or immediate).
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 out_result  output  XLEN  ALU result; 0 or 1 for branch compares.
REQ-015 out_taken  output  1  branch condition true; 0 for non-branch ops.
REQ-016 out_illegal  output  1  the op/funct3 combination is undecodable.

Function
REQ-017 Decode SHALL map op/funct3/funct7[5] to the 4-bit core ALU codes: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 BEQ10 BNE11 BLT12 BGE13 BLTU14 BGEU15.
REQ-018 Opcodes 0110011 and 0010011 SHALL decode by funct3. funct7[5] SHALL select SUB only for 0110011. funct7[5] SHALL select SRA/SRAI for both opcodes.
REQ-019 Opcodes 0000011, 0100011, 1100111, 1101111, 0110111 and 0010111 SHALL decode as ADD.
REQ-020 Opcode 1100011 SHALL decode as a branch. funct3 010 or 011 under this opcode SHALL be illegal.
REQ-021 Any other opcode SHALL be illegal.
REQ-022 FSM states SHALL be IDLE, EXEC, SHIFT and DONE. in_ready SHALL equal 1 only in IDLE.
REQ-023 When in_valid&in_ready: operands and the decoded code SHALL be latched, and the next state SHALL be EXEC.
REQ-024 EXEC, non-shift op: the result SHALL be computed and registered, and the next state SHALL be DONE, so out_valid rises 2 cycles after the accept edge.
REQ-025 EXEC, shift op with shamt=b[4:0]: if shamt is 0, go to DONE with result=a. Otherwise load the counter with shamt and go to SHIFT.
REQ-026 SHIFT: each cycle shift 1 bit (SRA replicates the sign bit) and decrement the counter. Go to DONE when the counter reaches 1, giving shamt cycles in SHIFT.
REQ-027 DONE: out_valid=1. Outputs SHALL be held stable until out_ready. Next state on out_valid&out_ready SHALL be IDLE.
REQ-028 Illegal op: EXEC SHALL go directly to DONE with result=0, out_taken=0 and out_illegal=1.
REQ-029 All arithmetic SHALL be mod 2^32. SLT/BLT/BGE SHALL compare signed; SLTU/BLTU/BGEU SHALL compare unsigned.
REQ-030 flush=1 in any state SHALL force IDLE on the next edge and clear out_valid. flush SHALL take priority over accept and over out_ready.
REQ-031 No new accept SHALL occur in the same cycle a result is consumed; a back-to-back minimum of 3 cycles per non-shift op.

Reset
REQ-032 rstn=0 SHALL immediately force IDLE, with out_valid=0, out_result=0, out_taken=0, out_illegal=0 and counter=0.
REQ-033 Reset mid-SHIFT or mid-DONE SHALL discard the operation. in_ready SHALL be 1 from the first edge after rstn rises.

Configuration
REQ-034 Macro Z_CORE_ALU_SEQ_FAST_SHIFT_EN, when defined: shifts SHALL complete in EXEC with a barrel shifter, same latency as other ops, and the SHIFT state SHALL be unreachable.
REQ-035 When the macro is undefined: serial shifting SHALL follow REQ-025 and REQ-026.

Verification
REQ-036 ADD, a=0x7FFFFFFF, b=1, out_ready=1 -> out_result=0x80000000, out_valid 2 cycles after accept, single pulse.
REQ-037 SRA, a=0x80000000, b=4 -> out_result=0xF8000000, out_valid 6 cycles after accept (macro undefined) or 2 cycles after accept (macro defined).
REQ-038 BLTU, a=1, b=0xFFFFFFFF -> out_taken=1 and out_result=1. BLT with the same operands -> out_taken=0.
REQ-039 Result pending, out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout. Result accepted on the 6th cycle.
REQ-040 Flush during SHIFT of SLL b=31 -> IDLE next cycle, no out_valid. A new ADD is then accepted normally.
REQ-041 Opcode 0000000 -> out_illegal=1, out_result=0. rstn low mid-operation -> all outputs 0 immediately.

Source files
------------

// File: rtl/z_core_alu_seq.sv
// z_core_alu_seq: sequential RV32 ALU with decode, serial shifter and a valid/ready handshake.
// Define Z_CORE_ALU_SEQ_FAST_SHIFT_EN to replace the serial shifter with a single-cycle barrel shifter.
module z_core_alu_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      in_op,
   input  logic [2:0]      in_funct3,
   input  logic [6:0]      in_funct7,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic            out_taken,
   output logic            out_illegal
);
   localparam logic [1:0] S_IDLE = 2'd0, S_EXEC = 2'd1, S_SHIFT = 2'd2, S_DONE = 2'd3;
   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                          ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                          ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_BEQ = 4'd10, ALU_BNE = 4'd11,
                          ALU_BLT = 4'd12, ALU_BGE = 4'd13, ALU_BLTU = 4'd14, ALU_BGEU = 4'd15;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [3:0]      code_q, code_d;
   logic            bad_q, bad_d, taken_q, taken_d, ill_q, ill_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [3:0]      dec_code;
   logic            dec_ill;
   logic [XLEN-1:0] alu_res;
   logic            alu_taken, is_shift, lt_s, lt_u, eq;
   logic [4:0]      shamt;
   logic            unused_funct7;

   assign unused_funct7 = ^{in_funct7[6], in_funct7[4:0]};
   assign shamt     = b_q[4:0];
   assign lt_s      = $signed(a_q) < $signed(b_q);
   assign lt_u      = a_q < b_q;
   assign eq        = a_q == b_q;
   assign is_shift  = (code_q == ALU_SLL) || (code_q == ALU_SRL) || (code_q == ALU_SRA);
   assign in_ready  = state_q == S_IDLE;
   assign out_valid = state_q == S_DONE;
   assign out_result  = res_q;
   assign out_taken   = taken_q;
   assign out_illegal = ill_q;

   always_comb begin
      dec_code = ALU_ADD;
      dec_ill  = 1'b0;
      case (in_op)
         7'b0110011, 7'b0010011:
            case (in_funct3)
               3'b000:  dec_code = (in_op == 7'b0110011 && in_funct7[5]) ? ALU_SUB : ALU_ADD;
               3'b001:  dec_code = ALU_SLL;
               3'b010:  dec_code = ALU_SLT;
               3'b011:  dec_code = ALU_SLTU;
               3'b100:  dec_code = ALU_XOR;
               3'b101:  dec_code = in_funct7[5] ? ALU_SRA : ALU_SRL;
               3'b110:  dec_code = ALU_OR;
               default: dec_code = ALU_AND;
            endcase
         7'b0000011, 7'b0100011, 7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111:
            dec_code = ALU_ADD;
         7'b1100011: begin
            // funct3 000/001 -> BEQ/BNE, 1xx -> BLT..BGEU; 010/011 have no branch
            dec_code = in_funct3[2] ? {2'b11, in_funct3[1:0]} : {3'b101, in_funct3[0]};
            dec_ill  = in_funct3[2:1] == 2'b01;
         end
         default: dec_ill = 1'b1;
      endcase
   end

   always_comb begin
      alu_taken = 1'b0;
      alu_res   = '0;
      case (code_q)
         ALU_BEQ:  alu_taken = eq;
         ALU_BNE:  alu_taken = ~eq;
         ALU_BLT:  alu_taken = lt_s;
         ALU_BGE:  alu_taken = ~lt_s;
         ALU_BLTU: alu_taken = lt_u;
         ALU_BGEU: alu_taken = ~lt_u;
         default:  alu_taken = 1'b0;
      endcase
      case (code_q)
         ALU_ADD:  alu_res = a_q + b_q;
         ALU_SUB:  alu_res = a_q - b_q;
`ifdef Z_CORE_ALU_SEQ_FAST_SHIFT_EN
         ALU_SLL:  alu_res = a_q << shamt;
         ALU_SRL:  alu_res = a_q >> shamt;
         ALU_SRA:  alu_res = $unsigned($signed(a_q) >>> shamt);
`endif
         ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
         ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
         ALU_XOR:  alu_res = a_q ^ b_q;
         ALU_OR:   alu_res = a_q | b_q;
         ALU_AND:  alu_res = a_q & b_q;
         default:  alu_res = {{(XLEN-1){1'b0}}, alu_taken};
      endcase
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      code_d  = code_q;
      bad_d   = bad_q;
      res_d   = res_q;
      taken_d = taken_q;
      ill_d   = ill_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE:
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               code_d  = dec_code;
               bad_d   = dec_ill;
               res_d   = '0;
               taken_d = 1'b0;
               ill_d   = 1'b0;
               state_d = S_EXEC;
            end
         S_EXEC: begin
            state_d = S_DONE;
            res_d   = bad_q ? '0 : alu_res;
            taken_d = alu_taken & ~bad_q;
            ill_d   = bad_q;
`ifndef Z_CORE_ALU_SEQ_FAST_SHIFT_EN
            if (!bad_q && is_shift) begin
               res_d = a_q;
               if (shamt != 5'd0) begin
                  cnt_d   = shamt;
                  state_d = S_SHIFT;
               end
            end
`endif
         end
         S_SHIFT: begin
            res_d   = (code_q == ALU_SLL) ? {res_q[XLEN-2:0], 1'b0}
                                          : {(code_q == ALU_SRA) & res_q[XLEN-1], res_q[XLEN-1:1]};
            cnt_d   = cnt_q - 5'd1;
            state_d = (cnt_q == 5'd1) ? S_DONE : S_SHIFT;
         end
         default:
            if (out_ready) state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         code_q  <= ALU_ADD;
         bad_q   <= 1'b0;
         res_q   <= '0;
         taken_q <= 1'b0;
         ill_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         code_q  <= code_d;
         bad_q   <= bad_d;
         res_q   <= res_d;
         taken_q <= taken_d;
         ill_q   <= ill_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_z_core_alu_seq.sv
// tb_z_core_alu_seq: directed and random checks of z_core_alu_seq against a behavioural model.
module tb_z_core_alu_seq;
   logic        clk = 1'b0, rstn = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [6:0]  in_op = '0, in_funct7 = '0;
   logic [2:0]  in_funct3 = '0;
   logic [31:0] in_a = '0, in_b = '0;
   logic        in_ready, out_valid, out_taken, out_illegal;
   logic [31:0] out_result;
   int          n_vec = 0, n_err = 0;

   z_core_alu_seq #(.XLEN(32)) dut (
      .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_taken(out_taken), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic t, output logic il, output int lat);
      int sh;
      sh = int'(b[4:0]);
      r = 0; t = 0; il = 0; lat = 2;
      if (op == 7'b0110011 || op == 7'b0010011) begin
         case (f3)
            3'd0: r = (op == 7'b0110011 && f7[5]) ? a - b : a + b;
            3'd1: begin r = a << sh; lat = 2 + sh; end
            3'd2: r = ($signed(a) < $signed(b)) ? 1 : 0;
            3'd3: r = (a < b) ? 1 : 0;
            3'd4: r = a ^ b;
            3'd5: begin r = f7[5] ? $unsigned($signed(a) >>> sh) : a >> sh; lat = 2 + sh; end
            3'd6: r = a | b;
            default: r = a & b;
         endcase
      end else if (op inside {7'b0000011, 7'b0100011, 7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111})
         r = a + b;
      else if (op == 7'b1100011) begin
         case (f3)
            3'd0: t = a == b;
            3'd1: t = a != b;
            3'd4: t = $signed(a) < $signed(b);
            3'd5: t = $signed(a) >= $signed(b);
            3'd6: t = a < b;
            3'd7: t = a >= b;
            default: il = 1;
         endcase
         r = t ? 1 : 0;
      end else
         il = 1;
`ifdef Z_CORE_ALU_SEQ_FAST_SHIFT_EN
      lat = 2;
`endif
   endfunction

   task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input int hold);
      logic [31:0] er;
      logic        et, ei;
      int          el, edges;
      model(op, f3, f7, a, b, er, et, ei, el);
      @(negedge clk);
      chk("in_ready_idle", in_ready, 1);
      in_valid = 1; in_op = op; in_funct3 = f3; in_funct7 = f7; in_a = a; in_b = b;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      in_valid = 0;
      while (!out_valid && edges < 200) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      chk("out_valid", out_valid, 1);
      chk("latency", edges, el);
      chk("result", out_result, er);
      chk("taken", out_taken, et);
      chk("illegal", out_illegal, ei);
      chk("in_ready_busy", in_ready, 0);
      repeat (hold) begin
         @(posedge clk);
         @(negedge clk);
         chk("hold_valid", out_valid, 1);
         chk("hold_result", out_result, er);
         chk("hold_taken", out_taken, et);
         chk("hold_ready", in_ready, 0);
      end
      out_ready = 1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 0;
      chk("consumed", out_valid, 0);
      chk("ready_after", in_ready, 1);
   endtask

   initial begin
      int seen;
      logic [6:0] ops [10];
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100111,
              7'b1101111, 7'b0110111, 7'b0010111, 7'b1100011, 7'b0000000};
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_result", out_result, 0);
      chk("rst_taken", out_taken, 0);
      chk("rst_illegal", out_illegal, 0);
      repeat (2) @(negedge clk);
      rstn = 1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);

      run_op(7'b0110011, 3'b000, 7'h00, 32'h7FFF_FFFF, 32'h1, 0);
      run_op(7'b0110011, 3'b101, 7'h20, 32'h8000_0000, 32'h4, 0);
      run_op(7'b1100011, 3'b110, 7'h00, 32'h1, 32'hFFFF_FFFF, 0);
      run_op(7'b1100011, 3'b100, 7'h00, 32'h1, 32'hFFFF_FFFF, 0);
      run_op(7'b0110011, 3'b000, 7'h20, 32'h5, 32'h7, 5);
      run_op(7'b0000000, 3'b000, 7'h00, 32'h1234, 32'h5678, 0);
      run_op(7'b1100011, 3'b010, 7'h00, 32'h3, 32'h3, 0);
      run_op(7'b0010011, 3'b101, 7'h20, 32'hF000_0000, 32'h0000_0408, 1);
      run_op(7'b0010011, 3'b000, 7'h20, 32'h10, 32'h3, 0);
      run_op(7'b0110011, 3'b001, 7'h00, 32'h1, 32'h0, 0);

      // flush wins over accept in IDLE
      @(negedge clk);
      in_valid = 1; flush = 1; in_op = 7'b0110011; in_funct3 = 3'b000;
      @(posedge clk);
      @(negedge clk);
      in_valid = 0; flush = 0;
      chk("flush_vs_accept", in_ready, 1);

      // flush in the middle of a long serial shift
      in_valid = 1; in_op = 7'b0110011; in_funct3 = 3'b001; in_funct7 = 0; in_a = 1; in_b = 31;
      @(posedge clk);
      @(negedge clk);
      in_valid = 0;
      @(posedge clk);
      @(negedge clk);
      flush = 1;
      @(posedge clk);
      @(negedge clk);
      flush = 0;
      chk("flush_valid", out_valid, 0);
      chk("flush_ready", in_ready, 1);
      seen = 0;
      repeat (35) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("flush_no_result", seen, 0);
      run_op(7'b0110011, 3'b000, 7'h00, 32'h11, 32'h22, 0);

      for (int i = 0; i < 40; i++) begin
         logic [6:0] op;
         op = ops[$urandom_range(0, 9)];
         if (op == 7'b0000000) op = 7'($urandom);
         run_op(op, 3'($urandom), ($urandom_range(0, 1) != 0) ? 7'h20 : 7'($urandom),
                $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                $urandom_range(0, 2));
      end

      // asynchronous reset in the middle of a shift
      @(negedge clk);
      in_valid = 1; in_op = 7'b0110011; in_funct3 = 3'b101; in_funct7 = 7'h20;
      in_a = 32'h8765_4321; in_b = 32'd20;
      @(posedge clk);
      @(negedge clk);
      in_valid = 0;
      repeat (3) @(negedge clk);
      rstn = 0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_result", out_result, 0);
      chk("arst_taken", out_taken, 0);
      chk("arst_illegal", out_illegal, 0);
      @(negedge clk);
      rstn = 1;
      @(posedge clk);
      @(negedge clk);
      chk("arst_ready", in_ready, 1);
      run_op(7'b0110011, 3'b111, 7'h00, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
